// File: rtl/audio_serial_tx.sv
// Frame-paced 16-bit mono-to-stereo serializer for a left-justified DAC, MSB first.
// Optional macro AUDIO_TX_UNDERRUN_MUTE_EN: an underrun frame sends silence instead of repeating the last sample.
module audio_serial_tx #(
  parameter int DIV_LOG2  = 3,
  parameter int READY_POS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] SampleIn,
  input  logic        SampleValid,
  output logic        ready,
  output logic        Bclk,
  output logic        Lrclk,
  output logic        Sdata,
  output logic        Underrun,
  output logic        Overrun
);

  localparam int            CW      = 6 + DIV_LOG2;
  localparam logic [CW-1:0] LAST    = CW'((64 << DIV_LOG2) - 1);
  localparam logic [CW-1:0] RDY_PRE = CW'(READY_POS - 1);

  // Handshake: ready is a one-cycle request once per frame; the source answers
  // with a one-cycle SampleValid at any later cycle up to and including the
  // frame's last cycle. SampleValid is never back-pressured.

  logic [CW-1:0] fcnt;
  logic [31:0]   fw;
  logic [15:0]   hold;
  logic [15:0]   last;
  logic          pend;

  logic          load;
  logic [4:0]    idx;
  logic [31:0]   fw_nxt;
  logic [15:0]   last_nxt;
  logic          pend_nxt;
  logic          under_nxt;
  logic          over_nxt;

  assign load = (fcnt == LAST);
  assign idx  = fcnt[CW-1:DIV_LOG2+1];

  always_comb begin
    fw_nxt    = fw;
    last_nxt  = last;
    pend_nxt  = pend;
    under_nxt = 1'b0;
    over_nxt  = 1'b0;
    if (load) begin
      // A sample arriving on the load cycle bypasses the holding register.
      if (SampleValid) begin
        fw_nxt   = {SampleIn, SampleIn};
        last_nxt = SampleIn;
        pend_nxt = 1'b0;
      end else if (pend) begin
        fw_nxt   = {hold, hold};
        last_nxt = hold;
        pend_nxt = 1'b0;
      end else begin
        under_nxt = 1'b1;
`ifdef AUDIO_TX_UNDERRUN_MUTE_EN
        fw_nxt   = 32'h0;
        last_nxt = 16'h0;
`else
        fw_nxt   = {last, last};
`endif
      end
    end else if (SampleValid) begin
      pend_nxt = 1'b1;
      over_nxt = pend;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fcnt     <= '0;
      fw       <= '0;
      hold     <= '0;
      last     <= '0;
      pend     <= 1'b0;
      ready    <= 1'b0;
      Bclk     <= 1'b0;
      Lrclk    <= 1'b0;
      Sdata    <= 1'b0;
      Underrun <= 1'b0;
      Overrun  <= 1'b0;
    end else begin
      fcnt     <= load ? '0 : fcnt + CW'(1);
      fw       <= fw_nxt;
      last     <= last_nxt;
      pend     <= pend_nxt;
      if (SampleValid) hold <= SampleIn;
      // Compare one count early so ready lines up with fcnt == READY_POS.
      ready    <= (fcnt == RDY_PRE);
      Bclk     <= fcnt[DIV_LOG2];
      Lrclk    <= fcnt[CW-1];
      Sdata    <= fw[5'd31 - idx];
      Underrun <= under_nxt;
      Overrun  <= over_nxt;
    end
  end

endmodule

// File: tb/tb_audio_serial_tx.sv
// Bench for audio_serial_tx: directed + random samples, frames decoded from the serial pins
// and checked against a frame-level reference model.
module tb_audio_serial_tx;

  localparam int DIV_LOG2  = 3;
  localparam int READY_POS = 10;
  localparam int FRAME     = 64 << DIV_LOG2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] SampleIn = 16'h0;
  logic        SampleValid = 1'b0;
  logic        ready, Bclk, Lrclk, Sdata, Underrun, Overrun;

  audio_serial_tx #(.DIV_LOG2(DIV_LOG2), .READY_POS(READY_POS)) dut (
    .clk(clk), .reset(reset), .SampleIn(SampleIn), .SampleValid(SampleValid),
    .ready(ready), .Bclk(Bclk), .Lrclk(Lrclk), .Sdata(Sdata),
    .Underrun(Underrun), .Overrun(Overrun)
  );

  // clock
  always #5 clk = ~clk;

  // reference model state
  int          m_fcnt;
  logic        m_pend;
  logic [15:0] m_hold, m_last;
  logic        e_under, e_over;
  logic [31:0] exp_q[$];

  // serial receiver state
  logic        prev_bclk;
  logic [31:0] rx;
  int          nbits;
  int          frames_rx;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_init();
    m_fcnt = 0; m_pend = 0; m_hold = 0; m_last = 0;
    e_under = 0; e_over = 0;
    exp_q.delete();
    exp_q.push_back(32'h0);
    prev_bclk = 0; rx = 0; nbits = 0;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_ready"}, 32'(ready), 32'h0);
    chk({tag, "_bclk"}, 32'(Bclk), 32'h0);
    chk({tag, "_lrclk"}, 32'(Lrclk), 32'h0);
    chk({tag, "_sdata"}, 32'(Sdata), 32'h0);
    chk({tag, "_under"}, 32'(Underrun), 32'h0);
    chk({tag, "_over"}, 32'(Overrun), 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; SampleValid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    reset = 1'b0;
    model_init();
  endtask

  // one clk of stimulus, model update at the edge, checks at the following negedge
  task automatic cycle(input logic valid, input logic [15:0] d);
    SampleValid = valid;
    SampleIn    = d;
    @(posedge clk);
    e_under = 0; e_over = 0;
    if (m_fcnt == FRAME - 1) begin
      if (valid) begin
        exp_q.push_back({d, d}); m_last = d; m_pend = 0; m_hold = d;
      end else if (m_pend) begin
        exp_q.push_back({m_hold, m_hold}); m_last = m_hold; m_pend = 0;
      end else begin
        e_under = 1;
`ifdef AUDIO_TX_UNDERRUN_MUTE_EN
        exp_q.push_back(32'h0); m_last = 0;
`else
        exp_q.push_back({m_last, m_last});
`endif
      end
    end else if (valid) begin
      e_over = m_pend; m_hold = d; m_pend = 1;
    end
    m_fcnt = (m_fcnt + 1) % FRAME;
    @(negedge clk);
    SampleValid = 1'b0;
    chk("underrun", 32'(Underrun), 32'(e_under));
    chk("overrun", 32'(Overrun), 32'(e_over));
    chk("ready", 32'(ready), 32'(m_fcnt == READY_POS));
    if (!prev_bclk && Bclk) begin
      chk("lrclk_at_bit", 32'(Lrclk), 32'(nbits >= 16));
      rx = {rx[30:0], Sdata};
      nbits++;
      if (nbits == 32) begin
        nbits = 0;
        frames_rx++;
        if (exp_q.size() == 0) chk("frame_unexpected", rx, 32'hxxxxxxxx);
        else chk("frame_word", rx, exp_q.pop_front());
      end
    end
    prev_bclk = Bclk;
  endtask

  task automatic run_to(input int pos);
    for (int i = 0; i <= FRAME && m_fcnt != pos; i++) cycle(1'b0, 16'($urandom));
    if (m_fcnt != pos) chk("run_to_bound", 32'(m_fcnt), 32'(pos));
  endtask

  task automatic send_at(input int pos, input logic [15:0] d);
    run_to(pos);
    cycle(1'b1, d);
  endtask

  task automatic finish_frame();
    if (m_fcnt != 0) begin
      run_to(FRAME - 1);
      cycle(1'b0, 16'h0);
    end
  endtask

  initial begin
    int n, p1, p2;
    frames_rx = 0;
    model_init();
    do_reset();

    // normal frame, then bypass on the last cycle of the frame
    send_at(50, 16'hA5C3);
    finish_frame();
    send_at(FRAME - 1, 16'h8001);
    // overrun: two samples in one frame
    send_at(100, 16'h1111);
    send_at(200, 16'h2222);
    finish_frame();
    // underrun: one sample, then a skipped frame
    send_at(60, 16'h7FFF);
    finish_frame();
    run_to(FRAME - 1);
    cycle(1'b0, 16'h0);
    run_to(FRAME - 1);
    cycle(1'b0, 16'h0);

    // random frames with 0..2 samples at random positions
    for (int f = 0; f < 8; f++) begin
      n = $urandom_range(0, 2);
      if (n == 1) begin
        p1 = ($urandom_range(0, 3) == 0) ? FRAME - 1 : $urandom_range(READY_POS, FRAME - 1);
        send_at(p1, 16'($urandom));
      end else if (n == 2) begin
        p1 = $urandom_range(READY_POS, 250);
        p2 = $urandom_range(p1 + 1, FRAME - 1);
        send_at(p1, 16'($urandom));
        send_at(p2, 16'($urandom));
      end
      finish_frame();
    end

    // asynchronous reset in the middle of a frame carrying data
    send_at(40, 16'h5A5A);
    finish_frame();
    run_to(300);
    reset = 1'b1;
    #1;
    check_zero_outputs("async_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_init();
    send_at(150, 16'hC0DE);
    finish_frame();
    run_to(FRAME - 1);
    cycle(1'b0, 16'h0);
    run_to(FRAME - 1);

    chk("frames_seen_min", 32'(frames_rx >= 12), 32'h1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
